// File: rtl/branch_resolve_queue_if.sv
// Interface: branch_resolve_queue_if
// Bundles the fetch push port, the execute resolve port, and the predictor-training and flush
// outputs of branch_resolve_queue.
//   master : fetch/execute side (drives fetch_* and resolve_*, observes queue status and training)
//   slave  : the queue itself
// Optional macro BRQ_STATS_EN adds the stat_branches / stat_mispredicts counters.
interface branch_resolve_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = 32
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              fetch_valid;
    logic [WORD_W-1:0] fetch_PC;
    logic [WORD_W-1:0] predicted_PC;
    logic              queue_full;
    logic              queue_empty;
    logic [CntW-1:0]   count;
    logic              resolve_valid;
    logic              resolve_is_branch;
    logic              resolve_taken;
    logic [WORD_W-1:0] resolve_target;
    logic              Wr_enable;
    logic              is_taken;
    logic [WORD_W-1:0] update_PC;
    logic [WORD_W-1:0] update_target_PC;
    logic              mispredict;
    logic [WORD_W-1:0] redirect_PC;
`ifdef BRQ_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
`endif

    modport master (
        output fetch_valid, fetch_PC, predicted_PC,
        output resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        input  queue_full, queue_empty, count,
        input  Wr_enable, is_taken, update_PC, update_target_PC, mispredict, redirect_PC
`ifdef BRQ_STATS_EN
        , input stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  fetch_valid, fetch_PC, predicted_PC,
        input  resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        output queue_full, queue_empty, count,
        output Wr_enable, is_taken, update_PC, update_target_PC, mispredict, redirect_PC
`ifdef BRQ_STATS_EN
        , output stat_branches, stat_mispredicts
`endif
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// Module: branch_resolve_queue
// In-order circular queue of fetched {PC, predicted next-PC} pairs. Execute resolves the oldest
// entry; the queue produces registered predictor-training outputs and a mispredict flush with the
// correct redirect PC.
// Ports:
//   CLK   : clock, all state updates on rising edge
//   nRST  : synchronous active-low reset
//   bus   : branch_resolve_queue_if.slave (push, resolve, status, training, flush)
// Optional macro BRQ_STATS_EN adds free-running branch and mispredict counters.
module branch_resolve_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = 32
) (
    input logic                  CLK,
    input logic                  nRST,
    branch_resolve_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WORD_W-1:0] pc_q   [DEPTH];
    logic [WORD_W-1:0] pred_q [DEPTH];
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q;

    logic              wr_q, taken_q, mis_q;
    logic [WORD_W-1:0] upc_q, utgt_q, redir_q;
`ifdef BRQ_STATS_EN
    logic [31:0]       stat_br_q, stat_mis_q;
`endif

    logic              full, empty, pop, push, flush_now;
    logic [WORD_W-1:0] head_pc, head_pred, act_pc;

    always_comb begin
        full      = (count_q == FullCnt);
        empty     = (count_q == '0);
        pop       = bus.resolve_valid & ~empty;
        head_pc   = pc_q[head_q];
        head_pred = pred_q[head_q];
        // Non-branches always fall through, whatever taken/target say.
        act_pc    = (bus.resolve_is_branch & bus.resolve_taken) ? bus.resolve_target
                                                                : head_pc + WORD_W'(4);
        flush_now = pop & (act_pc != head_pred);
        // Full is judged on the current count, so a pop does not make room this cycle.
        push      = bus.fetch_valid & ~full & ~flush_now;
    end

    // Entry storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_q[tail_q]   <= bus.fetch_PC;
            pred_q[tail_q] <= bus.predicted_PC;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            taken_q    <= 1'b0;
            mis_q      <= 1'b0;
            upc_q      <= '0;
            utgt_q     <= '0;
            redir_q    <= '0;
`ifdef BRQ_STATS_EN
            stat_br_q  <= '0;
            stat_mis_q <= '0;
`endif
        end else begin
            wr_q  <= pop & bus.resolve_is_branch;
            mis_q <= flush_now;
            // Payload holds its last value between pops.
            if (pop) begin
                taken_q <= bus.resolve_taken;
                upc_q   <= head_pc;
                utgt_q  <= bus.resolve_target;
                redir_q <= act_pc;
            end

            if (flush_now) begin
                // Everything younger than the mispredicted entry is wrong-path.
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (pop) head_q <= head_q + PtrW'(1);
                if (push) tail_q <= tail_q + PtrW'(1);
                if (push && !pop) count_q <= count_q + CntW'(1);
                else if (pop && !push) count_q <= count_q - CntW'(1);
            end

`ifdef BRQ_STATS_EN
            if (pop && bus.resolve_is_branch) stat_br_q <= stat_br_q + 32'd1;
            if (flush_now) stat_mis_q <= stat_mis_q + 32'd1;
`endif
        end
    end

    assign bus.queue_full       = full;
    assign bus.queue_empty      = empty;
    assign bus.count            = count_q;
    assign bus.Wr_enable        = wr_q;
    assign bus.is_taken         = taken_q;
    assign bus.update_PC        = upc_q;
    assign bus.update_target_PC = utgt_q;
    assign bus.mispredict       = mis_q;
    assign bus.redirect_PC      = redir_q;
`ifdef BRQ_STATS_EN
    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mis_q;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue: table-driven single-cycle vectors followed by
// hand-written fill/drain, wrap-around and reset sequences.
module tb_branch_resolve_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WORD_W = 32;

    logic CLK = 1'b0;
    logic nRST;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .WORD_W(WORD_W)) bus ();

    branch_resolve_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          fv;
        logic [31:0] fpc;
        logic [31:0] pred;
        bit          rv;
        bit          br;
        bit          tk;
        logic [31:0] tgt;
        bit          e_wr;
        bit          e_tk;
        logic [31:0] e_upc;
        logic [31:0] e_utgt;
        bit          e_mis;
        logic [31:0] e_redir;
        int          e_cnt;
        bit          chk_pay;
    } vec_t;

    localparam int NVec = 15;
    vec_t vecs [NVec];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit fv, input logic [31:0] fpc, input logic [31:0] pred,
                         input bit rv, input bit br, input bit tk, input logic [31:0] tgt);
        bus.fetch_valid       = fv;
        bus.fetch_PC          = fpc;
        bus.predicted_PC      = pred;
        bus.resolve_valid     = rv;
        bus.resolve_is_branch = br;
        bus.resolve_taken     = tk;
        bus.resolve_target    = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] base;
        string tag;

        // fv fpc pred | rv br tk tgt | wr tk upc utgt mis redir cnt chk
        vecs[0]  = '{1, 32'h100, 32'h104, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        vecs[1]  = '{0, 32'h0, 32'h0, 1, 0, 0, 32'h0,
                     0, 0, 32'h100, 32'h0, 0, 32'h104, 0, 1};
        vecs[2]  = '{1, 32'h200, 32'h240, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        vecs[3]  = '{0, 32'h0, 32'h0, 1, 1, 1, 32'h240,
                     1, 1, 32'h200, 32'h240, 0, 32'h240, 0, 1};
        vecs[4]  = '{0, 32'h0, 32'h0, 0, 0, 0, 32'h0,
                     0, 1, 32'h200, 32'h240, 0, 32'h240, 0, 1};
        vecs[5]  = '{1, 32'h300, 32'h304, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        vecs[6]  = '{1, 32'h304, 32'h308, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 2, 0};
        vecs[7]  = '{1, 32'h308, 32'h30C, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 3, 0};
        // Taken to 0x400 vs predicted 0x304: flush, and the concurrent push is dropped.
        vecs[8]  = '{1, 32'h500, 32'h504, 1, 1, 1, 32'h400,
                     1, 1, 32'h300, 32'h400, 1, 32'h400, 0, 1};
        vecs[9]  = '{0, 32'h0, 32'h0, 0, 0, 0, 32'h0,
                     0, 1, 32'h300, 32'h400, 0, 32'h400, 0, 1};
        vecs[10] = '{1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        // Not-taken at top of address space: PC+4 wraps to 0, matching prediction.
        vecs[11] = '{0, 32'h0, 32'h0, 1, 1, 0, 32'h1234,
                     1, 0, 32'hFFFF_FFFC, 32'h1234, 0, 32'h0, 0, 1};
        // Resolve while empty: no pulses, payload held.
        vecs[12] = '{0, 32'h0, 32'h0, 1, 1, 1, 32'h999,
                     0, 0, 32'hFFFF_FFFC, 32'h1234, 0, 32'h0, 0, 1};
        vecs[13] = '{1, 32'h600, 32'h700, 0, 0, 0, 32'h0,
                     0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        // Non-branch predicted as 0x700: falls through to 0x604, mispredict without training.
        vecs[14] = '{0, 32'h0, 32'h0, 1, 0, 1, 32'h700,
                     0, 1, 32'h600, 32'h700, 1, 32'h604, 0, 1};

        nRST = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.queue_empty), 32'd1);
        chk("rst_full", 32'(bus.queue_full), 32'd0);
        chk("rst_wr", 32'(bus.Wr_enable), 32'd0);
        chk("rst_mis", 32'(bus.mispredict), 32'd0);
        chk("rst_upc", bus.update_PC, 32'd0);
        chk("rst_redir", bus.redirect_PC, 32'd0);
        nRST = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].fv, vecs[i].fpc, vecs[i].pred, vecs[i].rv, vecs[i].br, vecs[i].tk,
                  vecs[i].tgt);
            tick();
            tag = $sformatf("v%0d", i);
            chk({tag, "_wr"}, 32'(bus.Wr_enable), 32'(vecs[i].e_wr));
            chk({tag, "_mis"}, 32'(bus.mispredict), 32'(vecs[i].e_mis));
            chk({tag, "_cnt"}, 32'(bus.count), 32'(vecs[i].e_cnt));
            chk({tag, "_empty"}, 32'(bus.queue_empty), 32'(vecs[i].e_cnt == 0));
            if (vecs[i].chk_pay) begin
                chk({tag, "_taken"}, 32'(bus.is_taken), 32'(vecs[i].e_tk));
                chk({tag, "_upc"}, bus.update_PC, vecs[i].e_upc);
                chk({tag, "_utgt"}, bus.update_target_PC, vecs[i].e_utgt);
                chk({tag, "_redir"}, bus.redirect_PC, vecs[i].e_redir);
            end
        end
        idle();

`ifdef BRQ_STATS_EN
        // Branch pops in v3, v8, v11; flushes in v8, v14.
        chk("stat_br", bus.stat_branches, 32'd3);
        chk("stat_mis", bus.stat_mispredicts, 32'd2);
`endif

        // Fill/drain three times; pointers start at 0 after the last flush and wrap each round.
        for (int r = 0; r < 3; r++) begin
            base = 32'h1000 + 32'(r) * 32'h100;
            for (int k = 0; k < DEPTH; k++) begin
                chk($sformatf("r%0d_full_pre%0d", r, k), 32'(bus.queue_full), 32'd0);
                drive(1'b1, base + 32'(4 * k), base + 32'(4 * k + 4), 1'b0, 1'b0, 1'b0, 32'h0);
                tick();
            end
            idle();
            chk($sformatf("r%0d_full", r), 32'(bus.queue_full), 32'd1);
            chk($sformatf("r%0d_cnt_full", r), 32'(bus.count), 32'(DEPTH));
            // Push while full with a simultaneous pop: push dropped.
            drive(1'b1, 32'hDEAD_0000, 32'hDEAD_0004, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            chk($sformatf("r%0d_cnt_drop", r), 32'(bus.count), 32'(DEPTH - 1));
            chk($sformatf("r%0d_upc0", r), bus.update_PC, base);
            chk($sformatf("r%0d_mis0", r), 32'(bus.mispredict), 32'd0);
            for (int k = 1; k < DEPTH; k++) begin
                drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
                tick();
                chk($sformatf("r%0d_upc%0d", r, k), bus.update_PC, base + 32'(4 * k));
                chk($sformatf("r%0d_mis%0d", r, k), 32'(bus.mispredict), 32'd0);
            end
            idle();
            chk($sformatf("r%0d_empty", r), 32'(bus.queue_empty), 32'd1);
        end

        // Push + pop without flush keeps count unchanged.
        drive(1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h2004, 32'h2008, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("pp_cnt", 32'(bus.count), 32'd1);
        chk("pp_upc", bus.update_PC, 32'h2000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h55);
        tick();
        chk("pp_upc2", bus.update_PC, 32'h2004);
        chk("pp_wr2", 32'(bus.Wr_enable), 32'd1);
        chk("pp_cnt2", 32'(bus.count), 32'd0);

        // Reset overrides a pending mispredicting pop and a push.
        drive(1'b1, 32'h3000, 32'h3004, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h3004, 32'h3008, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("pre_rst_cnt", 32'(bus.count), 32'd2);
        drive(1'b1, 32'h3008, 32'h300C, 1'b1, 1'b1, 1'b1, 32'h9000);
        nRST = 1'b0;
        tick();
        chk("mrst_cnt", 32'(bus.count), 32'd0);
        chk("mrst_wr", 32'(bus.Wr_enable), 32'd0);
        chk("mrst_mis", 32'(bus.mispredict), 32'd0);
        chk("mrst_upc", bus.update_PC, 32'd0);
`ifdef BRQ_STATS_EN
        chk("mrst_stat_br", bus.stat_branches, 32'd0);
        chk("mrst_stat_mis", bus.stat_mispredicts, 32'd0);
`endif
        nRST = 1'b1;
        idle();
        tick();
        chk("post_rst_empty", 32'(bus.queue_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
